led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
- Sequencer for the 8-bit serial-in/parallel-out LED shift register.
- Generates the serial data bit, the shift direction and a one-cycle shift enable at a slow step rate.
- Produces the "light up gradually, hold, turn off gradually, hold" effect, with direction taken from a board switch.
- Sits between the board switches/buttons and the shift register; the shift register advances only on shift_en.

Parameters:
- DIV, 25000000, clk cycles per step (0.5 s at 50 MHz); minimum 2.
- WIDTH, 8, number of LEDs = shift steps per fill or drain phase.
- HOLD_STEPS, 2, steps the pattern holds fully lit or fully dark; 0 means no hold.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run request (level).
- pause  in  1  freezes the sequence while high (level).
- sw_dir  in  1  direction switch: 1 = left-to-right (lr=1), 0 = right-to-left.
- s_in  out  1  serial bit for the shift register; valid whenever shift_en=1.
- lr  out  1  shift direction for the shift register; constant for a whole effect cycle.
- shift_en  out  1  one-clk pulse: the shift register shifts on this cycle.
- phase  out  3  current state encoding (debug/LED status).
- busy  out  1  high in any state except IDLE.
- cycle_done  out  1  one-clk pulse at the end of each full fill/hold/drain/hold cycle.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on reset; it overrides everything, including mid-phase.
- Reset values: state=IDLE; prescaler=0; step counter=0; s_in, lr, shift_en, busy, cycle_done all 0.
- Prescaler: counts 0..DIV-1 only while state != IDLE and pause=0, then wraps. A step tick occurs on the cycle where cnt==DIV-1. Pause holds cnt and all state unchanged; no tick is lost or duplicated.
- shift_en is registered: it is high for exactly one clk, the cycle after the tick. s_in and lr are stable in that cycle.
- States: IDLE, FILL, HOLD_FULL, DRAIN, HOLD_EMPTY (codes 0..4 on phase).
- IDLE: if en=1, go to FILL. On this transition: lr <= sw_dir, cnt <= 0, step <= 0.
- FILL: each tick gives s_in=1 and shift_en pulse, step++. After WIDTH shifts go to HOLD_FULL, step <= 0.
- HOLD_FULL: count HOLD_STEPS ticks with no shift_en, then go to DRAIN. If HOLD_STEPS=0, go to DRAIN directly after the last FILL shift.
- DRAIN: each tick gives s_in=0 and shift_en pulse. After WIDTH shifts go to HOLD_EMPTY.
- HOLD_EMPTY: count HOLD_STEPS ticks. On completion:
  - pulse cycle_done;
  - if en=1: go to FILL with lr <= sw_dir (re-sampled);
  - otherwise go to IDLE.
- en deasserted mid-cycle is ignored until HOLD_EMPTY completes, so the LEDs always end dark. busy stays 1 until then.
- sw_dir changes mid-cycle have no effect until the next cycle start.
- Counter widths: $clog2(DIV) for cnt; $clog2(max(WIDTH,HOLD_STEPS)+1) for step; no overflow permitted.
- Full cycle length: (2*WIDTH + 2*HOLD_STEPS) * DIV clks.
- Simultaneous pause and tick cycle: pause wins and the tick is deferred.

Decomposition:
- Shared package led_effect_pkg: state encoding constants (IDLE..HOLD_EMPTY), default DIV/WIDTH values.
- One sub-module, led_tick_gen: DIV prescaler with enable and clear, output tick pulse.
- The FSM, step counter and output registers live in led_seq_ctrl.

Test Plan:
- Reset, then en=1, sw_dir=1, DIV=4, WIDTH=8, HOLD_STEPS=2 -> 8 shift_en pulses 4 clks apart with s_in=1 and lr=1; then 8 clks with no pulse; then 8 pulses with s_in=0; cycle_done exactly 80 clks after FILL entry.
- With an 8-bit SIPO model attached, run one cycle -> pattern goes 0x80, 0xC0 ... 0xFF, holds 0xFF, then 0x7F ... 0x00. Repeat with sw_dir=0 -> 0x01, 0x03 ... 0xFF, then drain to 0x00.
- Toggle sw_dir mid-FILL -> lr unchanged until the next FILL entry, where it takes the new value.
- Hold pause=1 for 10 clks mid-DRAIN -> no shift_en and phase constant. After release, remaining pulse spacing is preserved (total cycle 90 clks).
- Drop en during FILL -> sequence completes through HOLD_EMPTY, cycle_done pulses, phase=0, busy=0, SIPO model reads 0x00.
- Assert reset mid-HOLD_FULL -> next clk all outputs 0 and phase=IDLE. With en still 1, FILL restarts and the first shift_en comes 4 clks later.

Source files
------------

// File: rtl/led_effect_pkg.sv
// Shared definitions for the LED fill/drain effect sequencer.
//   led_state_e    : sequencer state, also driven out on the phase port
//   DEF_*          : default timing / geometry for a 50 MHz board with 8 LEDs
package led_effect_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FILL       = 3'd1,
        ST_HOLD_FULL  = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_HOLD_EMPTY = 3'd4
    } led_state_e;

    localparam int DEF_DIV        = 25_000_000;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_HOLD_STEPS = 2;

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler.
//   clk   : system clock
//   reset : synchronous, active-high
//   en    : count enable; counter holds its value while low
//   clr   : forces the counter to 0 (wins over en)
//   tick  : high on the enabled cycle where the counter sits at DIV-1
module led_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A tick is only reported on a cycle that actually advances the counter,
    // so a disabled (paused) cycle defers the tick instead of dropping it.
    assign tick = en && !clr && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Sequencer for an 8-bit SIPO LED shift register: fill with ones, hold lit,
// drain with zeros, hold dark, repeat while en is high.
//   clk, reset : system clock, synchronous active-high reset
//   en         : run request (level), only looked at on a cycle boundary
//   pause      : freezes prescaler and sequence while high
//   sw_dir     : 1 = left-to-right, latched at each cycle start
//   s_in, lr   : serial data and direction for the shift register
//   shift_en   : one-clock shift strobe, the cycle after a step tick
//   phase      : current state code
//   busy       : state is not IDLE
//   cycle_done : one-clock pulse after the last hold step of a cycle
module led_seq_ctrl
    import led_effect_pkg::*;
#(
    parameter int DIV        = DEF_DIV,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HOLD_STEPS = DEF_HOLD_STEPS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       pause,
    input  logic       sw_dir,
    output logic       s_in,
    output logic       lr,
    output logic       shift_en,
    output logic [2:0] phase,
    output logic       busy,
    output logic       cycle_done
);

    localparam int STEP_MAX = (WIDTH > HOLD_STEPS) ? WIDTH : HOLD_STEPS;
    localparam int STEP_W   = $clog2(STEP_MAX + 1);
    localparam logic [STEP_W-1:0] SHIFT_LAST = STEP_W'(WIDTH - 1);
    localparam logic [STEP_W-1:0] HOLD_LAST  = STEP_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

    led_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              s_in_q, s_in_d;
    logic              lr_q, lr_d;
    logic              shift_en_q, shift_en_d;
    logic              cycle_done_q, cycle_done_d;

    logic tick;
    logic tick_clr;
    logic cycle_end;

    led_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    ((state_q != ST_IDLE) && !pause),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        s_in_d       = s_in_q;
        lr_d         = lr_q;
        shift_en_d   = 1'b0;
        cycle_done_d = 1'b0;
        tick_clr     = 1'b0;
        cycle_end    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en && !pause) begin
                    state_d  = ST_FILL;
                    lr_d     = sw_dir;
                    step_d   = '0;
                    tick_clr = 1'b1;
                end
            end
            ST_FILL: begin
                if (tick) begin
                    s_in_d     = 1'b1;
                    shift_en_d = 1'b1;
                    if (step_q == SHIFT_LAST) begin
                        step_d = '0;
                        if (HOLD_STEPS == 0) state_d = ST_DRAIN;
                        else                 state_d = ST_HOLD_FULL;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            ST_HOLD_FULL: begin
                if (tick) begin
                    if (step_q == HOLD_LAST) begin
                        step_d  = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (tick) begin
                    s_in_d     = 1'b0;
                    shift_en_d = 1'b1;
                    if (step_q == SHIFT_LAST) begin
                        step_d = '0;
                        if (HOLD_STEPS == 0) cycle_end = 1'b1;
                        else                 state_d   = ST_HOLD_EMPTY;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            ST_HOLD_EMPTY: begin
                if (tick) begin
                    if (step_q == HOLD_LAST) begin
                        step_d    = '0;
                        cycle_end = 1'b1;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase

        // The prescaler has just wrapped to 0, so a restart needs no clear;
        // the next FILL step lands exactly DIV clocks later.
        if (cycle_end) begin
            cycle_done_d = 1'b1;
            if (en) begin
                state_d = ST_FILL;
                lr_d    = sw_dir;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            s_in_q       <= 1'b0;
            lr_q         <= 1'b0;
            shift_en_q   <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            s_in_q       <= s_in_d;
            lr_q         <= lr_d;
            shift_en_q   <= shift_en_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign s_in       = s_in_q;
    assign lr         = lr_q;
    assign shift_en   = shift_en_q;
    assign cycle_done = cycle_done_q;
    assign phase      = state_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl with DIV=4, WIDTH=8, HOLD_STEPS=2 and an 8-bit
// SIPO model fed by s_in/lr/shift_en. Expected shift pulses and cycle_done
// times are queued when a cycle is started and consumed by the monitor.
module tb_led_seq_ctrl;

    localparam int DIV = 4;
    localparam int WIDTH = 8;
    localparam int HOLD_STEPS = 2;

    typedef struct {
        int         cyc;
        bit         s_in;
        bit         lr;
        logic [7:0] pat;
    } pulse_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       pause = 1'b0;
    logic       sw_dir = 1'b0;
    logic       s_in, lr, shift_en, busy, cycle_done;
    logic [2:0] phase;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] sipo = 8'h00;
    pulse_t     exp_q[$];
    int         done_q[$];

    led_seq_ctrl #(
        .DIV        (DIV),
        .WIDTH      (WIDTH),
        .HOLD_STEPS (HOLD_STEPS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .pause      (pause),
        .sw_dir     (sw_dir),
        .s_in       (s_in),
        .lr         (lr),
        .shift_en   (shift_en),
        .phase      (phase),
        .busy       (busy),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shift register model plus scoreboard consumer.
    always @(negedge clk) begin
        pulse_t e;
        int     d;
        if (reset === 1'b1) sipo = 8'h00;
        if (shift_en === 1'b1) begin
            sipo = lr ? {s_in, sipo[7:1]} : {sipo[6:0], s_in};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: cyc=%0d s_in=%0b lr=%0b sipo=%h, required no pulse", cyc, s_in, lr, sipo);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || s_in !== e.s_in || lr !== e.lr || sipo !== e.pat) begin
                    errors++;
                    $display("FAIL pulse: cyc=%0d s_in=%0b lr=%0b sipo=%h, required cyc=%0d s_in=%0b lr=%0b sipo=%h",
                             cyc, s_in, lr, sipo, e.cyc, e.s_in, e.lr, e.pat);
                end
            end
        end
        if (cycle_done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL cycle_done_unexpected: cyc=%0d, required no pulse", cyc);
            end else begin
                d = done_q.pop_front();
                if (cyc != d) begin
                    errors++;
                    $display("FAIL cycle_done: cyc=%0d, required cyc=%0d", cyc, d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Queue one full effect cycle entered at edge k. Drain events after
    // k+pause_at are delayed by pause_len clocks.
    task automatic push_cycle(input int k, input bit dir, input int pause_at, input int pause_len);
        pulse_t     p;
        logic [7:0] ones;
        ones = 8'hFF;
        for (int i = 0; i < WIDTH; i++) begin
            p.cyc  = k + DIV * (i + 1);
            p.s_in = 1'b1;
            p.lr   = dir;
            p.pat  = dir ? ~(ones >> (i + 1)) : ~(ones << (i + 1));
            exp_q.push_back(p);
        end
        for (int i = 0; i < WIDTH; i++) begin
            p.cyc  = k + DIV * (WIDTH + HOLD_STEPS + i + 1);
            if (pause_len > 0 && p.cyc > k + pause_at) p.cyc += pause_len;
            p.s_in = 1'b0;
            p.lr   = dir;
            p.pat  = dir ? (ones >> (i + 1)) : (ones << (i + 1));
            exp_q.push_back(p);
        end
        done_q.push_back(k + DIV * (2 * WIDTH + 2 * HOLD_STEPS) + pause_len);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({phase, busy, shift_en, s_in, lr, cycle_done} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: phase=%0d busy=%0b shift_en=%0b s_in=%0b lr=%0b done=%0b, required all 0",
                     phase, busy, shift_en, s_in, lr, cycle_done);
        end
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (phase !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_en: phase=%0d busy=%0b, required 0 0", phase, busy);
        end
    endtask

    task automatic test_fill_cycle(output int k);
        sw_dir = 1'b1;
        en     = 1'b1;
        k      = cyc + 1;
        push_cycle(k, 1'b1, 0, 0);
        wait_to(k);
        checks++;
        if (phase !== 3'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_entry: phase=%0d busy=%0b, required 1 1", phase, busy);
        end
        wait_to(k + 36);
        checks++;
        if (phase !== 3'd2 || sipo !== 8'hFF) begin
            errors++;
            $display("FAIL hold_full: phase=%0d sipo=%h, required 2 ff", phase, sipo);
        end
        wait_to(k + 60);
        checks++;
        if (phase !== 3'd3) begin
            errors++;
            $display("FAIL drain_phase: phase=%0d, required 3", phase);
        end
        wait_to(k + 76);
        checks++;
        if (phase !== 3'd4 || sipo !== 8'h00) begin
            errors++;
            $display("FAIL hold_empty: phase=%0d sipo=%h, required 4 00", phase, sipo);
        end
        wait_to(k + 80);
        checks++;
        if (phase !== 3'd1 || lr !== 1'b1) begin
            errors++;
            $display("FAIL restart: phase=%0d lr=%0b, required 1 1", phase, lr);
        end
    endtask

    task automatic test_pause(input int k);
        push_cycle(k, 1'b1, 50, 10);
        wait_to(k + 50);
        checks++;
        if (phase !== 3'd3) begin
            errors++;
            $display("FAIL pause_start_phase: phase=%0d, required 3", phase);
        end
        pause = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (phase !== 3'd3 || shift_en !== 1'b0) begin
                errors++;
                $display("FAIL paused: cyc=%0d phase=%0d shift_en=%0b, required 3 0", cyc, phase, shift_en);
            end
        end
        pause = 1'b0;
        wait_to(k + 90);
        checks++;
        if (phase !== 3'd1) begin
            errors++;
            $display("FAIL pause_restart: phase=%0d, required 1", phase);
        end
    endtask

    task automatic test_dir_toggle(input int k);
        push_cycle(k, 1'b1, 0, 0);
        wait_to(k + 10);
        sw_dir = 1'b0;
        wait_to(k + 40);
        checks++;
        if (lr !== 1'b1) begin
            errors++;
            $display("FAIL lr_mid_cycle: lr=%0b, required 1", lr);
        end
        wait_to(k + 80);
        checks++;
        if (lr !== 1'b0 || phase !== 3'd1) begin
            errors++;
            $display("FAIL lr_next_cycle: lr=%0b phase=%0d, required 0 1", lr, phase);
        end
    endtask

    task automatic test_en_drop(input int k);
        push_cycle(k, 1'b0, 0, 0);
        wait_to(k + 10);
        en = 1'b0;
        wait_to(k + 79);
        checks++;
        if (busy !== 1'b1 || phase !== 3'd4) begin
            errors++;
            $display("FAIL en_drop_busy: busy=%0b phase=%0d, required 1 4", busy, phase);
        end
        wait_to(k + 80);
        checks++;
        if (phase !== 3'd0 || busy !== 1'b0 || sipo !== 8'h00) begin
            errors++;
            $display("FAIL en_drop_end: phase=%0d busy=%0b sipo=%h, required 0 0 00", phase, busy, sipo);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (phase !== 3'd0) begin
            errors++;
            $display("FAIL en_drop_idle: phase=%0d, required 0", phase);
        end
    endtask

    task automatic test_reset_mid_hold();
        int     k, k2;
        pulse_t p;
        sw_dir = 1'b1;
        en     = 1'b1;
        k      = cyc + 1;
        for (int i = 0; i < WIDTH; i++) begin
            p.cyc  = k + DIV * (i + 1);
            p.s_in = 1'b1;
            p.lr   = 1'b1;
            p.pat  = 8'hFF << (WIDTH - 1 - i);
            exp_q.push_back(p);
        end
        wait_to(k + 34);
        checks++;
        if (phase !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset_phase: phase=%0d, required 2", phase);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({phase, busy, shift_en, s_in, lr, cycle_done} !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: phase=%0d busy=%0b shift_en=%0b s_in=%0b lr=%0b done=%0b, required all 0",
                     phase, busy, shift_en, s_in, lr, cycle_done);
        end
        reset = 1'b0;
        k2 = cyc + 1;
        p.cyc  = k2 + DIV;
        p.s_in = 1'b1;
        p.lr   = 1'b1;
        p.pat  = 8'h80;
        exp_q.push_back(p);
        wait_to(k2 + 6);
        checks++;
        if (phase !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_fill: phase=%0d, required 1", phase);
        end
        en    = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int k;
        @(negedge clk);
        test_reset();
        test_fill_cycle(k);
        test_pause(k + 80);
        test_dir_toggle(k + 170);
        test_en_drop(k + 250);
        test_reset_mid_hold();
        checks++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect: pulses=%0d dones=%0d, required 0 0", exp_q.size(), done_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
